// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage and its next-PC mux.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID
  } state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: jump > taken branch > sequential.
module npc_calc
  import mips_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [25:0]     instr_i,
  input  logic            branch_i,
  input  logic            bne_i,
  input  logic            jump_i,
  input  logic            zero_i,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic [PC_W-1:0] next_pc_o
);

  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;
  logic            br_taken;

  assign pc_plus4_o = pc_i + {{(PC_W-3){1'b0}}, 3'd4};
  assign br_off     = {{(PC_W-18){instr_i[15]}}, instr_i[15:0], 2'b00};
  assign br_target  = pc_plus4_o + br_off;
  assign jmp_target = {pc_plus4_o[PC_W-1:28], instr_i[25:0], 2'b00};
  // BEQ and BNE together cover both zero outcomes, so that case is always taken.
  assign br_taken   = (branch_i & zero_i) | (bne_i & ~zero_i);

  always_comb begin
    next_pc_o = pc_plus4_o;
    if (jump_i) begin
      next_pc_o = jmp_target;
    end else if (br_taken) begin
      next_pc_o = br_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches over a req/ack port.
// Optional FETCH_PERF_EN macro enables the saturating imem stall counter.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         op,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch,
  input  logic               bne,
  input  logic               jump,
  input  logic               zero,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus4,
  output logic [31:0]        stall_cnt
);

  state_t               state_q;
  logic [PC_W-1:0]      pc_q;
  logic [PC_W-1:0]      pc_d;
  logic [INSTR_W-1:0]   instr_q;
  logic                 valid_q;
  logic                 req_q;

  npc_calc #(
    .PC_W (PC_W)
  ) u_npc_calc (
    .pc_i       (pc_q),
    .instr_i    (instr_q[25:0]),
    .branch_i   (branch),
    .bne_i      (bne),
    .jump_i     (jump),
    .zero_i     (zero),
    .pc_plus4_o (pc_plus4),
    .next_pc_o  (pc_d)
  );

  // instr_ready only matters in S_VALID and imem_ack only in S_REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= S_VALID;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            pc_q    <= pc_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[OP_MSB:OP_LSB];
  assign instr_valid = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state_q == S_REQ) && !imem_ack && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner cases, a vector table, random traffic.
module tb_fetch_unit;

`ifdef FETCH_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req, imem_ack, instr_valid, instr_ready;
  logic        branch, bne, jump, zero;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, stall_cnt;
  logic [5:0]  op;

  logic        j_req, j_ack, j_valid, j_ready, j_jump;
  logic [31:0] j_addr, j_rdata, j_instr, j_pc, j_pc_plus4, j_stall;
  logic [5:0]  j_op;

  fetch_unit #(
    .PC_W     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .bne         (bne),
    .jump        (jump),
    .zero        (zero),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .stall_cnt   (stall_cnt)
  );

  // Second instance starts in the 0x1000_0000 region to exercise the jump region bits.
  fetch_unit #(
    .PC_W     (32),
    .RESET_PC (32'h1000_0008)
  ) dut_j (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (j_req),
    .imem_addr   (j_addr),
    .imem_ack    (j_ack),
    .imem_rdata  (j_rdata),
    .instr       (j_instr),
    .op          (j_op),
    .instr_valid (j_valid),
    .instr_ready (j_ready),
    .branch      (1'b0),
    .bne         (1'b0),
    .jump        (j_jump),
    .zero        (1'b0),
    .pc          (j_pc),
    .pc_plus4    (j_pc_plus4),
    .stall_cnt   (j_stall)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic        br;
    logic        bn;
    logic        jp;
    logic        z;
    int          delay;
    logic [31:0] next;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_stall;
  logic [31:0] cur_word;
  vec_t        tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC from the ISA rules, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                             input logic br, input logic bn, input logic jp,
                                             input logic z);
    logic [31:0] p4;
    int          imm;
    p4 = cur + 32'd4;
    if (jp) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
    if ((br && z) || (bn && !z)) begin
      imm = int'($signed(w[15:0]));
      return p4 + 32'(imm * 4);
    end
    return p4;
  endfunction

  task automatic do_reset;
    reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    branch = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0;
    step;
    step;
    exp_pc    = 32'h0;
    exp_stall = 32'h0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", instr_valid, 32'h0);
    chk("rst_req", imem_req, 32'h0);
    chk("rst_stall", stall_cnt, 32'h0);
    reset = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] word, input int delay, input bit noise);
    for (int i = 0; i < delay; i++) begin
      imem_ack    = 1'b0;
      imem_rdata  = $urandom;
      instr_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("req_wait", imem_req, 32'h1);
      chk("addr_stable", imem_addr, exp_pc);
      step;
    end
    imem_ack    = 1'b1;
    imem_rdata  = word;
    instr_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    chk("req", imem_req, 32'h1);
    chk("addr", imem_addr, exp_pc);
    step;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    imem_rdata  = $urandom;
    cur_word    = word;
    if (Perf) exp_stall = exp_stall + 32'(delay);
    chk("valid", instr_valid, 32'h1);
    chk("instr", instr, word);
    chk("op", {26'h0, op}, word >> 26);
    chk("req_drop", imem_req, 32'h0);
    chk("pc", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk("stall", stall_cnt, exp_stall);
  endtask

  task automatic retire(input logic br, input logic bn, input logic jp, input logic z,
                        input int hold, input bit noise);
    for (int i = 0; i < hold; i++) begin
      instr_ready = 1'b0;
      imem_ack    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata  = $urandom;
      step;
      chk("hold_valid", instr_valid, 32'h1);
      chk("hold_instr", instr, cur_word);
      chk("hold_req", imem_req, 32'h0);
    end
    imem_ack = 1'b0;
    branch = br; bne = bn; jump = jp; zero = z;
    instr_ready = 1'b1;
    step;
    instr_ready = 1'b0;
    branch = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0;
    exp_pc = model_next(exp_pc, cur_word, br, bn, jp, z);
    chk("ret_valid", instr_valid, 32'h0);
    chk("ret_req", imem_req, 32'h1);
    chk("next_addr", imem_addr, exp_pc);
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0000, 32'h0022_0820, 1'b0, 1'b0, 1'b0, 1'b0, 3, 32'h0000_0004};
    tbl[1]  = '{32'h0000_0004, 32'h1000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h0000_0008};
    tbl[2]  = '{32'h0000_0008, 32'h1000_0003, 1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h0000_0018};
    tbl[3]  = '{32'h0000_0018, 32'h1400_0005, 1'b0, 1'b1, 1'b0, 1'b1, 2, 32'h0000_001C};
    tbl[4]  = '{32'h0000_001C, 32'h1400_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0000_0018};
    tbl[5]  = '{32'h0000_0018, 32'h0800_0004, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0010};
    tbl[6]  = '{32'h0000_0010, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1, 32'h0000_0010};
    tbl[7]  = '{32'h0000_0010, 32'h1000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0000_0018};
    tbl[8]  = '{32'h0000_0018, 32'h0800_0040, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h0000_0100};
    tbl[9]  = '{32'h0000_0100, 32'h1000_0002, 1'b1, 1'b1, 1'b0, 1'b1, 0, 32'h0000_010C};
    tbl[10] = '{32'h0000_010C, 32'h1000_8000, 1'b1, 1'b0, 1'b0, 1'b1, 0, 32'hFFFE_0110};
    tbl[11] = '{32'hFFFE_0110, 32'h0800_0000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'hF000_0000};

    imem_rdata = 32'h0;
    j_ack = 1'b0; j_rdata = 32'h0; j_ready = 1'b0; j_jump = 1'b0;

    // Reset release with a same-cycle ack.
    do_reset;
    chk("idle_req", imem_req, 32'h0);
    step;
    fetch(32'hAC22_0004, 0, 1'b0);

    // Reset while a fetch is pending and ack arrives: the ack is discarded.
    do_reset;
    step;
    chk("s6_req_pre", imem_req, 32'h1);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step;
    chk("s6_instr", instr, 32'h0);
    chk("s6_valid", instr_valid, 32'h0);
    chk("s6_pc", pc, 32'h0);
    chk("s6_req", imem_req, 32'h0);
    chk("s6_stall", stall_cnt, 32'h0);
    reset = 1'b0; imem_ack = 1'b0;
    step;
    exp_pc = 32'h0; exp_stall = 32'h0;
    chk("s6_rereq", imem_req, 32'h1);

    for (int i = 0; i < 12; i++) begin
      chk("tbl_addr", imem_addr, tbl[i].addr);
      fetch(tbl[i].word, tbl[i].delay, 1'b0);
      retire(tbl[i].br, tbl[i].bn, tbl[i].jp, tbl[i].z, 0, 1'b0);
      chk("tbl_next", imem_addr, tbl[i].next);
    end

    for (int n = 0; n < 150; n++) begin
      logic br, bn, jp, z;
      fetch($urandom, int'($urandom_range(0, 3)), 1'b1);
      jp = ($urandom_range(0, 3) == 0);
      br = 1'($urandom_range(0, 1));
      bn = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      retire(br, bn, jp, z, int'($urandom_range(0, 2)), 1'b1);
    end

    // Jump keeps the upper region bits of pc+4.
    chk("j_req", j_req, 32'h1);
    chk("j_addr", j_addr, 32'h1000_0008);
    j_ack = 1'b1; j_rdata = 32'h0800_0040;
    step;
    j_ack = 1'b0;
    chk("j_valid", j_valid, 32'h1);
    chk("j_op", {26'h0, j_op}, 32'h2);
    chk("j_instr", j_instr, 32'h0800_0040);
    chk("j_plus4", j_pc_plus4, 32'h1000_000C);
    j_ready = 1'b1; j_jump = 1'b1;
    step;
    j_ready = 1'b0; j_jump = 1'b0;
    chk("j_target", j_addr, 32'h1000_0100);
    chk("j_pc", j_pc, 32'h1000_0100);
    if (!Perf) chk("j_stall", j_stall, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
